// File: rtl/gb_hram_intc.sv
// rtl/gb_hram_intc.sv - Game Boy high-page responder: IF, IE and HRAM
//
// Purpose:
//    Serves the Interrupt Flag register (0xFF0F), High RAM (0xFF80-0xFFFE)
//    and the Interrupt Enable register (0xFFFF) on the CPU bus. Rising edges
//    on the peripheral irq lines set IF bits. The CPU acknowledge clears the
//    lowest-indexed pending IF bit.
//
// Ports:
//    clk                  in   1   machine clock, shared with the CPU
//    reset                in   1   synchronous active-high reset
//    cpu_addr             in   16  CPU address bus
//    cpu_data_wr          in   8   CPU write data
//    cpu_wren             in   1   write strobe for this cycle
//    irq                  in   5   request levels (VBlank, STAT, Timer, Serial, Joypad)
//    clear_interrupt_flag in   1   CPU interrupt acknowledge
//    cpu_data_rd          out  8   combinational read data (0xFF when not hit)
//    hit                  out  1   cpu_addr decodes to this block
//    reg_IF               out  8   registered {3'b000, IF}
//    reg_IE               out  8   registered IE

module gb_hram_intc #(
   parameter int NUM_IRQ = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [15:0]         cpu_addr,
   input  logic [7:0]          cpu_data_wr,
   input  logic                cpu_wren,
   input  logic [NUM_IRQ-1:0]  irq,
   input  logic                clear_interrupt_flag,
   output logic [7:0]          cpu_data_rd,
   output logic                hit,
   output logic [7:0]          reg_IF,
   output logic [7:0]          reg_IE
);

   logic [NUM_IRQ-1:0] if_q;
   logic [NUM_IRQ-1:0] if_next;
   logic [NUM_IRQ-1:0] irq_prev;
   logic [NUM_IRQ-1:0] irq_edge;
   logic [NUM_IRQ-1:0] if_lowest;
   logic [7:0]         ie_q;

   // Entry 127 maps to 0xFFFF (IE) and is never written or read.
   logic [7:0]         hram [0:127];

   logic sel_if;
   logic sel_ie;
   logic sel_hram;

   assign sel_if   = (cpu_addr == 16'hFF0F);
   assign sel_ie   = (cpu_addr == 16'hFFFF);
   assign sel_hram = (cpu_addr[15:7] == 9'h1FF) && (cpu_addr[6:0] != 7'h7F);
   assign hit      = sel_if | sel_ie | sel_hram;

   always_comb begin
      cpu_data_rd = 8'hFF;
      if (sel_if)
         cpu_data_rd = {{(8 - NUM_IRQ){1'b1}}, if_q};
      else if (sel_ie)
         cpu_data_rd = ie_q;
      else if (sel_hram)
         cpu_data_rd = hram[cpu_addr[6:0]];
   end

   assign irq_edge  = irq & ~irq_prev;
   // Two's-complement trick isolates the lowest set bit of IF.
   assign if_lowest = if_q & (~if_q + 1'b1);

   // Acknowledge first, a CPU write then replaces the result, and new edges
   // are ORed in last so a fresh request is never lost.
   always_comb begin
      if_next = if_q;
      if (clear_interrupt_flag)
         if_next = if_q & ~if_lowest;
      if (cpu_wren && sel_if)
         if_next = cpu_data_wr[NUM_IRQ-1:0];
      if_next = if_next | irq_edge;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_q     <= '0;
         ie_q     <= 8'h00;
         // Loading the live level means a line already high at release is not an edge.
         irq_prev <= irq;
      end else begin
         if_q     <= if_next;
         irq_prev <= irq;
         if (cpu_wren && sel_ie)
            ie_q <= cpu_data_wr;
      end
   end

   // HRAM has no reset; a write coinciding with reset is still discarded.
   always_ff @(posedge clk) begin
      if (!reset && cpu_wren && sel_hram)
         hram[cpu_addr[6:0]] <= cpu_data_wr;
   end

   assign reg_IF = {{(8 - NUM_IRQ){1'b0}}, if_q};
   assign reg_IE = ie_q;

endmodule

// File: tb/tb_gb_hram_intc.sv
// tb/tb_gb_hram_intc.sv - directed self-checking bench for gb_hram_intc

module tb_gb_hram_intc;

   logic        clk;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_wr;
   logic        cpu_wren;
   logic [4:0]  irq;
   logic        clear_interrupt_flag;
   logic [7:0]  cpu_data_rd;
   logic        hit;
   logic [7:0]  reg_IF;
   logic [7:0]  reg_IE;

   int tests_run;
   int tests_failed;

   gb_hram_intc #(.NUM_IRQ(5)) dut (
      .clk                  (clk),
      .reset                (reset),
      .cpu_addr             (cpu_addr),
      .cpu_data_wr          (cpu_data_wr),
      .cpu_wren             (cpu_wren),
      .irq                  (irq),
      .clear_interrupt_flag (clear_interrupt_flag),
      .cpu_data_rd          (cpu_data_rd),
      .hit                  (hit),
      .reg_IF               (reg_IF),
      .reg_IE               (reg_IE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clk);
      cpu_addr    = addr;
      cpu_data_wr = data;
      cpu_wren    = 1'b1;
      @(negedge clk);
      cpu_wren    = 1'b0;
   endtask

   task automatic test_reset;
      irq   = 5'b00001;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (reg_IF !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_if_during got=%h exp=00", reg_IF);
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (reg_IF !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_if_after[%0d] got=%h exp=00", i, reg_IF);
         end
      end
      cpu_addr = 16'hFF0F;
      #1;
      tests_run++;
      if (cpu_data_rd !== 8'hE0 || hit !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_if_read got=%h hit=%b exp=e0 hit=1", cpu_data_rd, hit);
      end
      tests_run++;
      if (reg_IE !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_ie got=%h exp=00", reg_IE);
      end
   endtask

   task automatic test_write_read;
      bus_write(16'hFFFF, 8'h1F);
      bus_write(16'hFF80, 8'hA5);
      bus_write(16'hFFFE, 8'h3C);
      cpu_addr = 16'hFFFF; #1;
      tests_run++;
      if (cpu_data_rd !== 8'h1F || hit !== 1'b1) begin
         tests_failed++;
         $display("FAIL read_ie got=%h hit=%b exp=1f hit=1", cpu_data_rd, hit);
      end
      tests_run++;
      if (reg_IE !== 8'h1F) begin
         tests_failed++;
         $display("FAIL reg_ie got=%h exp=1f", reg_IE);
      end
      cpu_addr = 16'hFF80; #1;
      tests_run++;
      if (cpu_data_rd !== 8'hA5 || hit !== 1'b1) begin
         tests_failed++;
         $display("FAIL read_ff80 got=%h hit=%b exp=a5 hit=1", cpu_data_rd, hit);
      end
      cpu_addr = 16'hFFFE; #1;
      tests_run++;
      if (cpu_data_rd !== 8'h3C || hit !== 1'b1) begin
         tests_failed++;
         $display("FAIL read_fffe got=%h hit=%b exp=3c hit=1", cpu_data_rd, hit);
      end
      cpu_addr = 16'hFF7F; #1;
      tests_run++;
      if (cpu_data_rd !== 8'hFF || hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_ff7f got=%h hit=%b exp=ff hit=0", cpu_data_rd, hit);
      end
      cpu_addr = 16'hFF0E; #1;
      tests_run++;
      if (cpu_data_rd !== 8'hFF || hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL read_ff0e got=%h hit=%b exp=ff hit=0", cpu_data_rd, hit);
      end
      // Same-cycle read of the location being written returns the old byte.
      @(negedge clk);
      cpu_addr    = 16'hFF80;
      cpu_data_wr = 8'h5A;
      cpu_wren    = 1'b1;
      #1;
      tests_run++;
      if (cpu_data_rd !== 8'hA5) begin
         tests_failed++;
         $display("FAIL same_cycle_read got=%h exp=a5", cpu_data_rd);
      end
      @(negedge clk);
      cpu_wren = 1'b0;
      #1;
      tests_run++;
      if (cpu_data_rd !== 8'h5A) begin
         tests_failed++;
         $display("FAIL after_write_read got=%h exp=5a", cpu_data_rd);
      end
   endtask

   task automatic test_if_write;
      bus_write(16'hFF0F, 8'hFF);
      cpu_addr = 16'hFF0F; #1;
      tests_run++;
      if (cpu_data_rd !== 8'hFF) begin
         tests_failed++;
         $display("FAIL if_write_read got=%h exp=ff", cpu_data_rd);
      end
      tests_run++;
      if (reg_IF !== 8'h1F) begin
         tests_failed++;
         $display("FAIL if_write_reg got=%h exp=1f", reg_IF);
      end
      bus_write(16'hFF0F, 8'h00);
      tests_run++;
      if (reg_IF !== 8'h00) begin
         tests_failed++;
         $display("FAIL if_clear_reg got=%h exp=00", reg_IF);
      end
   endtask

   task automatic test_irq_ack;
      @(negedge clk);
      irq = 5'b00000;
      @(negedge clk);
      irq = 5'b00101;
      @(negedge clk);
      irq = 5'b00000;
      tests_run++;
      if (reg_IF !== 8'h05) begin
         tests_failed++;
         $display("FAIL irq_capture got=%h exp=05", reg_IF);
      end
      clear_interrupt_flag = 1'b1;
      @(negedge clk);
      clear_interrupt_flag = 1'b0;
      tests_run++;
      if (reg_IF !== 8'h04) begin
         tests_failed++;
         $display("FAIL ack_first got=%h exp=04", reg_IF);
      end
      clear_interrupt_flag = 1'b1;
      @(negedge clk);
      clear_interrupt_flag = 1'b0;
      tests_run++;
      if (reg_IF !== 8'h00) begin
         tests_failed++;
         $display("FAIL ack_second got=%h exp=00", reg_IF);
      end
      // Held level must not re-set IF after acknowledge.
      irq = 5'b00010;
      @(negedge clk);
      tests_run++;
      if (reg_IF !== 8'h02) begin
         tests_failed++;
         $display("FAIL level_capture got=%h exp=02", reg_IF);
      end
      clear_interrupt_flag = 1'b1;
      @(negedge clk);
      clear_interrupt_flag = 1'b0;
      @(negedge clk);
      tests_run++;
      if (reg_IF !== 8'h00) begin
         tests_failed++;
         $display("FAIL level_no_reset got=%h exp=00", reg_IF);
      end
      // Two-cycle acknowledge clears two bits.
      irq = 5'b11000;
      @(negedge clk);
      irq = 5'b00000;
      clear_interrupt_flag = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clear_interrupt_flag = 1'b0;
      tests_run++;
      if (reg_IF !== 8'h00) begin
         tests_failed++;
         $display("FAIL ack_two_cycle got=%h exp=00", reg_IF);
      end
   endtask

   task automatic test_ack_vs_edge;
      irq = 5'b00001;
      @(negedge clk);
      irq = 5'b00000;
      @(negedge clk);
      irq = 5'b00001;
      clear_interrupt_flag = 1'b1;
      @(negedge clk);
      clear_interrupt_flag = 1'b0;
      irq = 5'b00000;
      tests_run++;
      if (reg_IF !== 8'h01) begin
         tests_failed++;
         $display("FAIL ack_vs_edge got=%h exp=01", reg_IF);
      end
      clear_interrupt_flag = 1'b1;
      @(negedge clk);
      clear_interrupt_flag = 1'b0;
      tests_run++;
      if (reg_IF !== 8'h00) begin
         tests_failed++;
         $display("FAIL ack_after_edge got=%h exp=00", reg_IF);
      end
   endtask

   task automatic test_write_vs_edge;
      @(negedge clk);
      cpu_addr    = 16'hFF0F;
      cpu_data_wr = 8'h00;
      cpu_wren    = 1'b1;
      irq         = 5'b01000;
      @(negedge clk);
      cpu_wren = 1'b0;
      tests_run++;
      if (reg_IF !== 8'h08) begin
         tests_failed++;
         $display("FAIL write_vs_edge got=%h exp=08", reg_IF);
      end
      // Write replaces the acknowledge result.
      cpu_data_wr          = 8'hE3;
      cpu_wren             = 1'b1;
      clear_interrupt_flag = 1'b1;
      @(negedge clk);
      cpu_wren             = 1'b0;
      clear_interrupt_flag = 1'b0;
      tests_run++;
      if (reg_IF !== 8'h03) begin
         tests_failed++;
         $display("FAIL write_vs_ack got=%h exp=03", reg_IF);
      end
   endtask

   task automatic test_reset_mid;
      irq = 5'b00000;
      @(negedge clk);
      reset                = 1'b1;
      cpu_addr             = 16'hFFFF;
      cpu_data_wr          = 8'h55;
      cpu_wren             = 1'b1;
      clear_interrupt_flag = 1'b1;
      irq                  = 5'b10000;
      @(negedge clk);
      cpu_wren             = 1'b0;
      clear_interrupt_flag = 1'b0;
      tests_run++;
      if (reg_IF !== 8'h00 || reg_IE !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_mid got if=%h ie=%h exp if=00 ie=00", reg_IF, reg_IE);
      end
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (reg_IF !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_mid_held_irq got=%h exp=00", reg_IF);
      end
      cpu_addr = 16'hFF80; #1;
      tests_run++;
      if (cpu_data_rd !== 8'h5A) begin
         tests_failed++;
         $display("FAIL hram_survives_reset got=%h exp=5a", cpu_data_rd);
      end
   endtask

   initial begin
      tests_run            = 0;
      tests_failed         = 0;
      reset                = 1'b1;
      cpu_addr             = 16'h0000;
      cpu_data_wr          = 8'h00;
      cpu_wren             = 1'b0;
      irq                  = 5'b00000;
      clear_interrupt_flag = 1'b0;
      test_reset;
      test_write_read;
      test_if_write;
      test_irq_ack;
      test_ack_vs_edge;
      test_write_vs_edge;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
